// File: rtl/lsu_store_buffer_if.sv
// Store buffer port bundle: commit push channel, DCache drain channel,
// load forwarding probe and occupancy status.
interface lsu_store_buffer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic                  push_valid;
  logic                  push_ready;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [DATA_WIDTH-1:0] push_data;
  logic [STRB_W-1:0]     push_wstrb;
  logic                  push_uncached;

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [STRB_W-1:0]     req_wstrb;
  logic                  req_uncached;

  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [STRB_W-1:0]     ld_fwd_mask;
  logic [DATA_WIDTH-1:0] ld_fwd_data;

  logic                  empty;
  logic                  full;

  modport slave (
    input  push_valid, push_addr, push_data, push_wstrb, push_uncached,
    output push_ready,
    output req_valid, req_addr, req_data, req_wstrb, req_uncached,
    input  req_ready,
    input  ld_addr,
    output ld_fwd_mask, ld_fwd_data,
    output empty, full
  );

  modport master (
    output push_valid, push_addr, push_data, push_wstrb, push_uncached,
    input  push_ready,
    input  req_valid, req_addr, req_data, req_wstrb, req_uncached,
    output req_ready,
    output ld_addr,
    input  ld_fwd_mask, ld_fwd_data,
    input  empty, full
  );
endinterface

// File: rtl/lsu_store_buffer.sv
// Committed-store FIFO feeding the DCache write port in program order, with
// byte-granular store-to-load forwarding to younger loads.
module lsu_store_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  lsu_store_buffer_if.slave   sb
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;

  logic [ADDR_WIDTH-1:0] r_addr  [DEPTH];
  logic [DATA_WIDTH-1:0] r_data  [DEPTH];
  logic [STRB_W-1:0]     r_wstrb [DEPTH];
  logic [DEPTH-1:0]      r_unc;
  logic [DEPTH-1:0]      r_valid;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;

  logic [IDX_W-1:0]      w_head_idx;
  logic [IDX_W-1:0]      w_tail_idx;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push_fire;
  logic                  w_pop_fire;
  logic [IDX_W-1:0]      w_age_idx [DEPTH];
  logic [STRB_W-1:0]     w_fwd_mask;
  logic [DATA_WIDTH-1:0] w_fwd_data;

  assign w_head_idx  = r_head[IDX_W-1:0];
  assign w_tail_idx  = r_tail[IDX_W-1:0];
  // Equal indices: pointer MSB tells a full ring from an empty one
  assign w_empty     = (r_head == r_tail);
  assign w_full      = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
  assign w_push_fire = sb.push_valid & ~w_full;
  assign w_pop_fire  = ~w_empty & sb.req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_unc   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i]  <= '0;
        r_data[i]  <= '0;
        r_wstrb[i] <= '0;
      end
    end else begin
      if (w_push_fire) begin
        r_addr[w_tail_idx]  <= sb.push_addr;
        r_data[w_tail_idx]  <= sb.push_data;
        r_wstrb[w_tail_idx] <= sb.push_wstrb;
        r_unc[w_tail_idx]   <= sb.push_uncached;
        r_valid[w_tail_idx] <= 1'b1;
        r_tail              <= r_tail + PTR_W'(1);
      end
      if (w_pop_fire) begin
        r_valid[w_head_idx] <= 1'b0;
        r_head              <= r_head + PTR_W'(1);
      end
    end
  end

  assign sb.push_ready   = ~w_full;
  assign sb.empty        = w_empty;
  assign sb.full         = w_full;
  assign sb.req_valid    = ~w_empty;
  assign sb.req_addr     = r_valid[w_head_idx] ? r_addr[w_head_idx]  : '0;
  assign sb.req_data     = r_valid[w_head_idx] ? r_data[w_head_idx]  : '0;
  assign sb.req_wstrb    = r_valid[w_head_idx] ? r_wstrb[w_head_idx] : '0;
  assign sb.req_uncached = r_valid[w_head_idx] & r_unc[w_head_idx];

  // Storage index of the i-th oldest slot
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_age_idx[i] = w_head_idx + IDX_W'(i);
    end
  end

  // Walk oldest to youngest so the youngest matching strobe owns each lane
  always_comb begin
    w_fwd_mask = '0;
    w_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[w_age_idx[i]] &&
          (r_addr[w_age_idx[i]][ADDR_WIDTH-1:OFF_W] == sb.ld_addr[ADDR_WIDTH-1:OFF_W])) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (r_wstrb[w_age_idx[i]][b]) begin
            w_fwd_mask[b]        = 1'b1;
            w_fwd_data[b*8 +: 8] = r_data[w_age_idx[i]][b*8 +: 8];
          end
        end
      end
    end
  end

  assign sb.ld_fwd_mask = w_fwd_mask;
  assign sb.ld_fwd_data = w_fwd_data;

  always @(posedge clk) begin
    if (rst_n) begin
      assert (PTR_W'(r_tail - r_head) <= PTR_W'(DEPTH))
        else $error("store buffer occupancy exceeds DEPTH");
      assert (!(w_pop_fire && !r_valid[w_head_idx]))
        else $error("store buffer pop of an invalid head entry");
    end
  end

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Directed bench for lsu_store_buffer: stimulus queues expected DCache
// requests, a negedge monitor pops and compares each accepted request.
module tb_lsu_store_buffer;
  logic clk;
  logic rst_n;

  lsu_store_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) sb ();

  lsu_store_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        unc;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every accepted DCache request must match the oldest expected store
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && sb.req_valid && sb.req_ready) begin
        if (q.size() == 0) begin
          chk("req_unexpected", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          chk("req_addr", sb.req_addr, e.addr);
          chk("req_data", sb.req_data, e.data);
          chk("req_wstrb", 32'(sb.req_wstrb), 32'(e.strb));
          chk("req_uncached", 32'(sb.req_uncached), 32'(e.unc));
        end
      end
    end
  end

  task automatic push_begin(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic u, input logic exp_acc);
    exp_t e;
    sb.push_valid    = 1'b1;
    sb.push_addr     = a;
    sb.push_data     = d;
    sb.push_wstrb    = s;
    sb.push_uncached = u;
    #1;
    chk("push_ready", 32'(sb.push_ready), 32'(exp_acc));
    if (exp_acc) begin
      e.addr = a; e.data = d; e.strb = s; e.unc = u;
      q.push_back(e);
    end
  endtask

  task automatic push_end();
    @(posedge clk);
    #1;
    sb.push_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic u, input logic exp_acc);
    push_begin(a, d, s, u, exp_acc);
    push_end();
  endtask

  task automatic wait_empty();
    int n = 0;
    while (!sb.empty && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("drain_empty", 32'(sb.empty), 32'd1);
  endtask

  task automatic chk_fwd(input string name, input logic [31:0] la,
                         input logic [3:0] m, input logic [31:0] d);
    sb.ld_addr = la;
    #1;
    chk({name, "_mask"}, 32'(sb.ld_fwd_mask), 32'(m));
    chk({name, "_data"}, sb.ld_fwd_data, d);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n            = 1'b0;
    sb.push_valid    = 1'b0;
    sb.push_addr     = '0;
    sb.push_data     = '0;
    sb.push_wstrb    = '0;
    sb.push_uncached = 1'b0;
    sb.req_ready     = 1'b0;
    sb.ld_addr       = '0;
    #12;
    chk("rst_push_ready", 32'(sb.push_ready), 32'd1);
    chk("rst_req_valid", 32'(sb.req_valid), 32'd0);
    chk("rst_req_addr", sb.req_addr, 32'd0);
    chk("rst_req_data", sb.req_data, 32'd0);
    chk("rst_empty", 32'(sb.empty), 32'd1);
    chk("rst_full", 32'(sb.full), 32'd0);
    chk_fwd("rst_fwd", 32'h0, 4'h0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single push appears next cycle and holds while DCache stalls
    push(32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1);
    #1;
    chk("t1_req_valid", 32'(sb.req_valid), 32'd1);
    chk("t1_req_addr", sb.req_addr, 32'h100);
    chk("t1_empty", 32'(sb.empty), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      chk("t1_hold_addr", sb.req_addr, 32'h100);
      chk("t1_hold_data", sb.req_data, 32'hDEADBEEF);
    end
    sb.req_ready = 1'b1;
    wait_empty();
    sb.req_ready = 1'b0;

    // 2: fill, drop the fifth, drain in order (cached/uncached mixed)
    push(32'h10, 32'h1, 4'h1, 1'b0, 1'b1);
    push(32'h14, 32'h2, 4'h3, 1'b1, 1'b1);
    push(32'h18, 32'h3, 4'h7, 1'b0, 1'b1);
    push(32'h1C, 32'h4, 4'hF, 1'b1, 1'b1);
    #1;
    chk("t2_full", 32'(sb.full), 32'd1);
    chk("t2_push_ready", 32'(sb.push_ready), 32'd0);
    push(32'h20, 32'h5, 4'hF, 1'b0, 1'b0);
    sb.req_ready = 1'b1;
    wait_empty();
    sb.req_ready = 1'b0;

    // 3: full with push+pop together -> pop only, push lands the next cycle
    push(32'h40, 32'hA, 4'hF, 1'b0, 1'b1);
    push(32'h44, 32'hB, 4'hF, 1'b0, 1'b1);
    push(32'h48, 32'hC, 4'hF, 1'b0, 1'b1);
    push(32'h4C, 32'hD, 4'hF, 1'b0, 1'b1);
    sb.req_ready = 1'b1;
    push(32'h50, 32'hE, 4'hF, 1'b0, 1'b0);
    sb.req_ready = 1'b0;
    push(32'h50, 32'hE, 4'hF, 1'b0, 1'b1);
    #1;
    chk("t3_full_after_wrap", 32'(sb.full), 32'd1);
    sb.req_ready = 1'b1;
    wait_empty();
    sb.req_ready = 1'b0;

    // 4: byte merge across two stores to one word; same-cycle push excluded
    push(32'h200, 32'h11223344, 4'h3, 1'b0, 1'b1);
    push_begin(32'h202, 32'hAABB0000, 4'hC, 1'b0, 1'b1);
    chk_fwd("t4_inflight", 32'h200, 4'h3, 32'h00003344);
    push_end();
    chk_fwd("t4_merge", 32'h201, 4'hF, 32'hAABB3344);
    sb.req_ready = 1'b1;
    wait_empty();
    sb.req_ready = 1'b0;

    // 5: youngest wins, miss reads zero, popping entry still forwards
    push(32'h300, 32'h000000FF, 4'h1, 1'b1, 1'b1);
    push(32'h300, 32'h00000077, 4'h1, 1'b0, 1'b1);
    chk_fwd("t5_young", 32'h300, 4'h1, 32'h00000077);
    chk_fwd("t5_miss", 32'h304, 4'h0, 32'h0);
    sb.push_valid = 1'b0;
    sb.req_ready  = 1'b1;
    chk_fwd("t5_popping", 32'h300, 4'h1, 32'h00000077);
    wait_empty();
    sb.req_ready = 1'b0;
    chk_fwd("t5_drained", 32'h300, 4'h0, 32'h0);

    // 6: async reset mid-drain flushes everything; buffer works afterwards
    push(32'h600, 32'h61, 4'hF, 1'b0, 1'b1);
    push(32'h604, 32'h62, 4'hF, 1'b0, 1'b1);
    push(32'h608, 32'h63, 4'hF, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_req_valid", 32'(sb.req_valid), 32'd0);
    chk("t6_empty", 32'(sb.empty), 32'd1);
    chk_fwd("t6_fwd", 32'h600, 4'h0, 32'h0);
    q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(32'h700, 32'hCAFEF00D, 4'h5, 1'b1, 1'b1);
    sb.req_ready = 1'b1;
    wait_empty();
    sb.req_ready = 1'b0;

    @(posedge clk);
    #2;
    chk("end_queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
